axis_sum_arbiter: RTL
=====================

AXIS_SUM_ARBITER -- requirements
Module: axis_sum_arbiter

Interface
REQ-001 Parameter PAR_WDATA_BYTE, default 2: operand/sum width in bytes; W = 8*PAR_WDATA_BYTE; legal range 1..2.
REQ-002 Parameter PAR_NUM_CH, default 4: number of operand-pair channels; legal range 2..8; IW = $clog2(PAR_NUM_CH).
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 s_axis_tdata  input  [PAR_NUM_CH][2][W]  operand A (index 0) and operand B (index 1) per channel.
REQ-006 s_axis_tvalid  input  [PAR_NUM_CH][2]  valid per operand stream.
REQ-007 s_axis_tready  output  [PAR_NUM_CH][2]  ready per operand stream.
REQ-008 m_axis_tdata  output  W  registered sum.
REQ-009 m_axis_tdest  output  IW  index of the channel that produced the sum.
REQ-010 m_axis_tvalid  output  1  output valid.
REQ-011 m_axis_tready  input  1  downstream ready.

Function
REQ-012 Channel c is eligible when s_axis_tvalid[c][0] and s_axis_tvalid[c][1] are both high; a single tvalid never makes a channel eligible.
REQ-013 Output stage is one register slot (state EMPTY / FULL); slot can load when EMPTY, or when FULL and m_axis_tready=1 in the same cycle.
REQ-014 Grant: when slot can load and at least one channel is eligible, exactly one channel is granted, chosen round-robin starting from (last granted + 1) mod PAR_NUM_CH.
REQ-015 s_axis_tready[g][0] and s_axis_tready[g][1] are driven high in the grant cycle for granted channel g only; every other tready bit is low; tready does not depend on this-cycle tready of other channels.
REQ-016 Operands A and B of a channel are consumed together in the same cycle; never one without the other.
REQ-017 Loaded value: m_axis_tdata = (A + B) mod 2^W (carry discarded), m_axis_tdest = g; latency one cycle from grant to m_axis_tvalid.
REQ-018 Throughput one sum per cycle when m_axis_tready is held high and channels stay eligible.
REQ-019 FULL with m_axis_tready=0: m_axis_tdata, m_axis_tdest, m_axis_tvalid hold stable; no grant issued.
REQ-020 FULL with m_axis_tready=1 and no eligible channel: slot goes EMPTY, m_axis_tvalid low next cycle.
REQ-021 Round-robin pointer updates only on an actual grant; pointer wraps PAR_NUM_CH-1 -> 0.
REQ-022 A single channel eligible continuously receives every grant (no idle cycles inserted for fairness).

Reset
REQ-023 While aresetn=0: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tdest=0, all s_axis_tready=0, slot EMPTY, round-robin pointer so that channel 0 has highest priority at first grant.
REQ-024 Reset asserted mid-transfer discards the held sum without a handshake; no channel is granted in the first cycle after release.

Configuration
REQ-025 Macro AXIS_SUM_ARBITER_CARRY_EN defined: adds output port m_axis_tuser (1 bit) carrying the carry-out of A+B, registered with m_axis_tdata, reset 0; undefined: port absent and carry discarded, all other behaviour identical.

Verification
REQ-026 W=16, ch1 A=0x1234 B=0x0001, m_axis_tready=1 -> next cycle tdata=0x1235, tdest=1, tvalid=1; s_axis_tready[1] = 2'b11 for exactly one cycle.
REQ-027 Overflow A=0xFFFF B=0x0002 on ch0 -> tdata=0x0001; with AXIS_SUM_ARBITER_CARRY_EN tuser=1, else no tuser port.
REQ-028 All 4 channels eligible continuously, tready=1 -> tdest sequence 0,1,2,3,0,1 over six consecutive cycles, no bubbles.
REQ-029 ch2 only tvalid[2][0]=1, tvalid[2][1]=0 for 10 cycles -> no grant, tvalid=0, s_axis_tready all 0; raise tvalid[2][1] -> grant next cycle.
REQ-030 Output stalled (m_axis_tready=0) 5 cycles with sum 0x00AA held -> tdata/tdest/tvalid stable, all s_axis_tready=0; release -> handshake, next grant same cycle.
REQ-031 aresetn pulsed low while tvalid=1 and stalled -> tvalid=0 immediately (asynchronous), tdata=0; after release first grant goes to lowest-index eligible channel.

Source files
------------

// File: rtl/axis_sum_arbiter.sv
// ============================================================================
// axis_sum_arbiter
//
// Purpose:
//   Several AXI-Stream channels each present an operand pair (A, B). A channel
//   is eligible only when both of its operand streams are valid. One eligible
//   channel per cycle is granted round-robin, both operands are consumed
//   together, and (A + B) mod 2^W is loaded into a single-slot registered
//   output stage together with the index of the granted channel.
//
// Optional feature:
//   AXIS_SUM_ARBITER_CARRY_EN  - when defined, adds output m_axis_tuser which
//                                carries the carry-out of A + B, registered
//                                alongside m_axis_tdata. When undefined the
//                                port does not exist and the carry is dropped.
//
// Parameters:
//   PAR_WDATA_BYTE  operand/sum width in bytes (1..2), W = 8*PAR_WDATA_BYTE
//   PAR_NUM_CH      number of operand-pair channels (2..8)
//
// Ports:
//   aclk           in   clock, rising edge
//   aresetn        in   reset, asynchronous assert, active-low
//   s_axis_tdata   in   [PAR_NUM_CH][2][W]  operand A (idx 0) / B (idx 1)
//   s_axis_tvalid  in   [PAR_NUM_CH][2]     valid per operand stream
//   s_axis_tready  out  [PAR_NUM_CH][2]     ready per operand stream
//   m_axis_tdata   out  [W]                 registered sum
//   m_axis_tdest   out  [IW]                channel that produced the sum
//   m_axis_tvalid  out  1                   output valid
//   m_axis_tuser   out  1                   carry-out (only with CARRY_EN)
//   m_axis_tready  in   1                   downstream ready
// ============================================================================
module axis_sum_arbiter #(
    parameter int PAR_WDATA_BYTE = 2,
    parameter int PAR_NUM_CH     = 4,
    localparam int W             = 8 * PAR_WDATA_BYTE,
    localparam int IW            = $clog2(PAR_NUM_CH)
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [PAR_NUM_CH-1:0][1:0][W-1:0]  s_axis_tdata,
    input  logic [PAR_NUM_CH-1:0][1:0]         s_axis_tvalid,
    output logic [PAR_NUM_CH-1:0][1:0]         s_axis_tready,
    output logic [W-1:0]                       m_axis_tdata,
    output logic [IW-1:0]                      m_axis_tdest,
    output logic                               m_axis_tvalid,
`ifdef AXIS_SUM_ARBITER_CARRY_EN
    output logic                               m_axis_tuser,
`endif
    input  logic                               m_axis_tready
);

    // Candidate index arithmetic needs one spare bit so ptr + offset
    // cannot wrap before the explicit modulo-PAR_NUM_CH correction.
    localparam int CW = IW + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_rst_done;     // low for the first cycle after release
    logic [IW-1:0]           r_rr_ptr;       // highest-priority channel for next grant
    logic [W-1:0]            r_tdata;
    logic [IW-1:0]           r_tdest;
`ifdef AXIS_SUM_ARBITER_CARRY_EN
    logic                    r_tuser;
`endif

    logic                    w_can_load;
    logic [PAR_NUM_CH-1:0]   w_elig;
    logic [IW-1:0]           w_cand_idx [PAR_NUM_CH];
    logic                    w_pick_vld;
    logic [IW-1:0]           w_pick_idx;
    logic                    w_grant_vld;
    logic [IW-1:0]           w_grant_idx;
    logic [IW-1:0]           w_ptr_next;
    logic [W-1:0]            w_op_a;
    logic [W-1:0]            w_op_b;
`ifdef AXIS_SUM_ARBITER_CARRY_EN
    logic [W:0]              w_sum;
`else
    logic [W-1:0]            w_sum;
`endif

    // ------------------------------------------------------------------------
    // Eligibility: both operand streams of a channel must be valid.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < PAR_NUM_CH; gi++) begin : g_elig
        assign w_elig[gi] = s_axis_tvalid[gi][0] & s_axis_tvalid[gi][1];
    end

    // ------------------------------------------------------------------------
    // Round-robin candidate order: candidate k is (r_rr_ptr + k) mod N.
    // Works for non-power-of-two channel counts.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < PAR_NUM_CH; gi++) begin : g_cand
        logic [CW-1:0] w_raw;
        assign w_raw          = {1'b0, r_rr_ptr} + CW'(gi);
        assign w_cand_idx[gi] = (w_raw >= CW'(PAR_NUM_CH))
                              ? IW'(w_raw - CW'(PAR_NUM_CH))
                              : w_raw[IW-1:0];
    end

    // Scan candidates from lowest to highest priority so the
    // highest-priority eligible candidate is the last one written.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = PAR_NUM_CH - 1; k >= 0; k--) begin
            if (w_elig[w_cand_idx[k]]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand_idx[k];
            end
        end
    end

    // A grant needs room in the slot and is suppressed in the first
    // cycle after reset release.
    assign w_grant_vld = w_pick_vld & w_can_load & r_rst_done;
    assign w_grant_idx = w_pick_idx;
    assign w_ptr_next  = (w_grant_idx == IW'(PAR_NUM_CH - 1)) ? '0
                                                              : w_grant_idx + IW'(1);

    // Both operand streams of the granted channel are acknowledged together.
    for (genvar gi = 0; gi < PAR_NUM_CH; gi++) begin : g_ready
        assign s_axis_tready[gi] = {2{w_grant_vld && (w_grant_idx == IW'(gi))}};
    end

    // ------------------------------------------------------------------------
    // Adder on the granted channel's operands
    // ------------------------------------------------------------------------
    assign w_op_a = s_axis_tdata[w_grant_idx][0];
    assign w_op_b = s_axis_tdata[w_grant_idx][1];
`ifdef AXIS_SUM_ARBITER_CARRY_EN
    assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b};
`else
    assign w_sum  = w_op_a + w_op_b;
`endif

    // ------------------------------------------------------------------------
    // Output slot FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output slot FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant_vld) begin
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                // Drain with no refill empties the slot; a refill keeps it full.
                if (m_axis_tready && !w_grant_vld) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Output slot FSM: outputs
    always_comb begin
        w_can_load    = 1'b0;
        m_axis_tvalid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_can_load    = 1'b1;
                m_axis_tvalid = 1'b0;
            end
            ST_FULL: begin
                w_can_load    = m_axis_tready;
                m_axis_tvalid = 1'b1;
            end
            default: begin
                w_can_load    = 1'b0;
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Reset-release qualifier
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Payload registers and round-robin pointer; all change only on a grant,
    // so a stalled slot holds its contents.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata  <= '0;
            r_tdest  <= '0;
            r_rr_ptr <= '0;
        end else if (w_grant_vld) begin
            r_tdata  <= w_sum[W-1:0];
            r_tdest  <= w_grant_idx;
            r_rr_ptr <= w_ptr_next;
        end
    end

`ifdef AXIS_SUM_ARBITER_CARRY_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tuser <= 1'b0;
        end else if (w_grant_vld) begin
            r_tuser <= w_sum[W];
        end
    end

    assign m_axis_tuser = r_tuser;
`endif

    assign m_axis_tdata = r_tdata;
    assign m_axis_tdest = r_tdest;

endmodule
